// File: rtl/psum_post_proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_post_proc_pkg
//  Description : Shared definitions for the partial-sum post-processor and
//                the PE-array wrapper: default datapath widths and the
//                post-processor FSM state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_post_proc_pkg;

    // Default datapath geometry
    localparam int DEF_LANES  = 8;   // psum lanes per beat
    localparam int DEF_PSUM_W = 22;  // signed width of one input psum lane
    localparam int DEF_ACC_W  = 30;  // signed accumulator width per lane
    localparam int DEF_OUT_W  = 8;   // signed width of one output activation

    // Channel counter / channel-count configuration width
    localparam int CH_CNT_W   = 8;

    // Post-processor FSM
    //   ST_ACC  : accepting psum beats and accumulating
    //   ST_POST : one-cycle requantization of the finished group
    //   ST_OUT  : holding the activation word until the consumer takes it
    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_POST = 2'd1,
        ST_OUT  = 2'd2
    } pp_state_t;

endpackage : psum_post_proc_pkg
`default_nettype wire

// File: rtl/psum_post_proc_requant_lane.sv
`default_nettype none
// ============================================================================
//  Module      : requant_lane
//  Description : Combinational requantization of one accumulator lane:
//                round-half-up, arithmetic right shift, optional ReLU and
//                saturation to a signed OUT_W-bit activation.
//  Ports       : acc   - signed accumulator value (ACC_W bits)
//                shift - right-shift amount (0..31)
//                relu  - 1 = negative results become zero
//                q     - saturated signed activation (OUT_W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_lane
    import psum_post_proc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    input  logic             relu,
    output logic [OUT_W-1:0] q
);

    // Two guard bits: the rounding constant can reach 2^30, which must add to
    // a full-range accumulator without the sum changing sign.
    localparam int W = ACC_W + 2;

    localparam longint C_MAX_L = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint C_MIN_L = -(longint'(1) << (OUT_W - 1));
    localparam logic signed [W-1:0] C_MAX = W'(C_MAX_L);
    localparam logic signed [W-1:0] C_MIN = W'(C_MIN_L);

    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] w_rnd;
    logic signed [W-1:0] w_sum;
    logic signed [W-1:0] w_shr;

    always_comb begin
        w_ext = {{2{acc[ACC_W-1]}}, acc};
        w_rnd = '0;
        if (shift != 5'd0) begin
            w_rnd = {{(W-1){1'b0}}, 1'b1} << (shift - 5'd1);
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> shift;

        q = w_shr[OUT_W-1:0];
        if (relu && w_shr[W-1]) begin
            q = '0;
        end else if (w_shr > C_MAX) begin
            q = C_MAX[OUT_W-1:0];
        end else if (w_shr < C_MIN) begin
            q = C_MIN[OUT_W-1:0];
        end
    end

endmodule : requant_lane
`default_nettype wire

// File: rtl/psum_post_proc.sv
`default_nettype none
// ============================================================================
//  Module      : psum_post_proc
//  Description : Accumulates cfg_num_ch psum beats per output group across
//                LANES lanes, then requantizes every lane to an OUT_W-bit
//                activation and presents it on a valid/ready output.
//  Ports       : clk, rst (async, active-low)
//                cfg_num_ch/cfg_shift/cfg_relu - group configuration, sampled
//                                                on the first beat of a group
//                psum_valid/psum_ready/psum_data - input beat handshake
//                out_valid/out_ready/out_data    - output word handshake
//                busy - a group is in progress or a result is pending
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_post_proc
    import psum_post_proc_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_CNT_W-1:0]     cfg_num_ch,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [LANES*PSUM_W-1:0] psum_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic                    busy
);

    pp_state_t                  r_state;
    pp_state_t                  w_state_nxt;
    logic [CH_CNT_W-1:0]        r_ch_cnt;
    logic [CH_CNT_W-1:0]        r_num_ch;
    logic [4:0]                 r_shift;
    logic                       r_relu;
    logic signed [ACC_W-1:0]    r_acc [LANES];
    logic signed [ACC_W-1:0]    w_psum_ext [LANES];
    logic [LANES*OUT_W-1:0]     r_out_data;
    logic [LANES*OUT_W-1:0]     w_q;
    logic                       r_out_valid;
    logic                       w_accept;
    logic                       w_first;
    logic                       w_last;
    logic [CH_CNT_W-1:0]        w_num_ch_eff;

    // On the first beat the live configuration applies; afterwards the copy
    // latched with that beat does, so mid-group cfg changes are invisible.
    always_comb begin
        w_first      = (r_ch_cnt == '0);
        w_num_ch_eff = r_num_ch;
        if (w_first) begin
            w_num_ch_eff = (cfg_num_ch == '0) ? CH_CNT_W'(1) : cfg_num_ch;
        end
        w_last = (r_ch_cnt == (w_num_ch_eff - CH_CNT_W'(1)));
    end

    assign w_accept = psum_valid && psum_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        psum_ready  = 1'b0;
        case (r_state)
            ST_ACC: begin
                // Gated by rst so the port reads 0 while reset is held.
                psum_ready = rst;
                if (psum_valid && rst && w_last) begin
                    w_state_nxt = ST_POST;
                end
            end
            ST_POST: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-lane sign extension and requantization
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_psum_ext[gi] = {{(ACC_W-PSUM_W){psum_data[gi*PSUM_W + PSUM_W - 1]}},
                                     psum_data[gi*PSUM_W +: PSUM_W]};

            requant_lane #(
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_requant (
                .acc   (r_acc[gi]),
                .shift (r_shift),
                .relu  (r_relu),
                .q     (w_q[gi*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_cnt    <= '0;
            r_num_ch    <= CH_CNT_W'(1);
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_num_ch <= w_num_ch_eff;
                    r_shift  <= cfg_shift;
                    r_relu   <= cfg_relu;
                end
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= w_first ? w_psum_ext[i] : (r_acc[i] + w_psum_ext[i]);
                end
                r_ch_cnt <= w_last ? '0 : (r_ch_cnt + CH_CNT_W'(1));
            end

            if (r_state == ST_POST) begin
                r_out_data  <= w_q;
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_OUT) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_ACC) || (r_ch_cnt != '0);

endmodule : psum_post_proc
`default_nettype wire

// File: tb/tb_psum_post_proc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_post_proc
//  Description : Self-checking bench for psum_post_proc. A group-level model
//                (integer sums, queue of expected words) is compared against
//                every presented output word; directed cases pin the model
//                with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_post_proc;

    localparam int LANES  = 8;
    localparam int PSUM_W = 22;
    localparam int ACC_W  = 30;
    localparam int OUT_W  = 8;
    localparam int DW     = LANES * PSUM_W;
    localparam int OW     = LANES * OUT_W;
    localparam longint QMAX = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint QMIN = -(longint'(1) << (OUT_W - 1));

    logic          clk;
    logic          rst;
    logic [7:0]    cfg_num_ch;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          psum_valid;
    logic          psum_ready;
    logic [DW-1:0] psum_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          busy;

    psum_post_proc #(
        .LANES  (LANES),
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_num_ch (cfg_num_ch),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_data  (psum_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_err     = 0;
    int ready_pct = 100;
    int n_acc     = 0;

    // Group-level model state
    longint        m_sum [LANES];
    int            m_ch = 0;
    int            m_nc = 1;
    int            m_sh = 0;
    bit            m_rl = 1'b0;
    logic [OW-1:0] exp_q [$];

    function automatic longint ref_q(longint s, int sh, bit rl);
        longint v;
        v = s;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (rl && v < 0) v = 0;
        if (v > QMAX) v = QMAX;
        if (v < QMIN) v = QMIN;
        return v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Called just before the clock edge that accepts the beat.
    task automatic model_accept(input logic [DW-1:0] d, input int nc, input int sh, input bit rl);
        logic [OW-1:0] e;
        n_acc++;
        if (m_ch == 0) begin
            m_nc = (nc == 0) ? 1 : nc;
            m_sh = sh;
            m_rl = rl;
        end
        for (int i = 0; i < LANES; i++) begin
            longint v;
            v = longint'($signed(d[i*PSUM_W +: PSUM_W]));
            m_sum[i] = (m_ch == 0) ? v : (m_sum[i] + v);
        end
        m_ch++;
        if (m_ch == m_nc) begin
            e = '0;
            for (int i = 0; i < LANES; i++) begin
                e[i*OUT_W +: OUT_W] = OUT_W'(ref_q(m_sum[i], m_sh, m_rl));
            end
            exp_q.push_back(e);
            m_ch = 0;
        end
    endtask

    task automatic model_reset();
        m_ch = 0;
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input int nc, input int sh, input bit rl);
        int t;
        @(negedge clk);
        psum_data  = d;
        cfg_num_ch = 8'(nc);
        cfg_shift  = 5'(sh);
        cfg_relu   = rl;
        psum_valid = 1'b1;
        t = 0;
        while (!psum_ready) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                fail_timeout("psum_accept");
                psum_valid = 1'b0;
                return;
            end
        end
        model_accept(d, nc, sh, rl);
        @(posedge clk);
        #1 psum_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [OW-1:0] d, output int cyc);
        cyc = 0;
        d   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                d = out_data;
                return;
            end
            if (cyc > 600) begin
                fail_timeout("out_valid");
                return;
            end
        end
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge clk);
            t++;
            if (t > limit) begin
                fail_timeout("drain");
                return;
            end
        end
    endtask

    function automatic logic [DW-1:0] lane0(input int v);
        logic [DW-1:0] r;
        r = '0;
        r[PSUM_W-1:0] = PSUM_W'(v);
        return r;
    endfunction

    // Compare process: every presented word must be the oldest expected one.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
                    end else begin
                        chk("out_data", out_data, exp_q[0]);
                        chk("psum_ready_while_out", OW'(psum_ready), OW'(0));
                    end
                end
                out_ready = (int'($urandom_range(99)) < ready_pct);
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    initial begin
        logic [OW-1:0] d;
        logic [OW-1:0] hold;
        logic [DW-1:0] pd;
        int            c;
        int            acc0;
        int            t;
        int            nc;
        int            sh;
        int            nb;
        bit            rl;
        int            vin  [3];
        int            vnc  [3];
        bit            vrl  [3];
        logic [7:0]    vexp [3];

        rst        = 1'b0;
        cfg_num_ch = 8'd0;
        cfg_shift  = 5'd0;
        cfg_relu   = 1'b0;
        psum_valid = 1'b0;
        psum_data  = '0;

        // Reset state, including a beat offered during reset
        repeat (2) @(negedge clk);
        psum_valid = 1'b1;
        psum_data  = lane0(123);
        @(negedge clk);
        chk("rst_psum_ready", OW'(psum_ready), OW'(0));
        chk("rst_out_valid",  OW'(out_valid),  OW'(0));
        chk("rst_out_data",   out_data,        OW'(0));
        chk("rst_busy",       OW'(busy),       OW'(0));
        psum_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("psum_ready_after_rst", OW'(psum_ready), OW'(1));
        chk("busy_after_rst",       OW'(busy),       OW'(0));

        // Single-channel pass-through and 2-cycle latency
        send_beat(lane0(100), 1, 0, 1'b0);
        wait_out(d, c);
        chk("latency_cycles", OW'(c), OW'(2));
        chk("passthru_lane0", OW'(d[7:0]), OW'(100));
        drain(50);

        // Three-channel group with rounding; cfg on later beats must be ignored
        send_beat(lane0(10), 3, 2, 1'b0);
        chk("busy_mid_group", OW'(busy), OW'(1));
        send_beat(lane0(20), 1, 0, 1'b1);
        send_beat(lane0(-5), 7, 9, 1'b1);
        wait_out(d, c);
        chk("round_shift_lane0", OW'(d[7:0]), OW'(6));
        drain(50);
        chk("busy_idle", OW'(busy), OW'(0));

        // ReLU and saturation corners
        vin[0] = -300; vnc[0] = 1; vrl[0] = 1'b1; vexp[0] = 8'h00;
        vin[1] = -300; vnc[1] = 0; vrl[1] = 1'b0; vexp[1] = 8'h80;
        vin[2] = 1000; vnc[2] = 1; vrl[2] = 1'b0; vexp[2] = 8'h7F;
        for (int k = 0; k < 3; k++) begin
            send_beat(lane0(vin[k]), vnc[k], 0, vrl[k]);
            wait_out(d, c);
            chk("relu_sat_lane0", OW'(d[7:0]), OW'(vexp[k]));
            drain(50);
        end

        // Back-pressure: output held, pending beat waits for the handshake
        ready_pct = 0;
        send_beat(lane0(55), 1, 0, 1'b0);
        wait_out(hold, c);
        chk("bp_lane0", OW'(hold[7:0]), OW'(55));
        acc0 = n_acc;
        fork
            send_beat(lane0(9), 1, 0, 1'b0);
        join_none
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_data_stable", out_data,         hold);
            chk("bp_out_valid",       OW'(out_valid),   OW'(1));
            chk("bp_psum_ready",      OW'(psum_ready),  OW'(0));
            chk("bp_no_accept",       OW'(n_acc),       OW'(acc0));
        end
        ready_pct = 100;
        t = 0;
        while (n_acc == acc0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (n_acc == acc0) fail_timeout("bp_pending_accept");
        wait_out(d, c);
        chk("bp_pending_lane0", OW'(d[7:0]), OW'(9));
        drain(50);

        // Reset mid-group discards the partial sums
        send_beat(lane0(11), 4, 0, 1'b0);
        send_beat(lane0(11), 4, 0, 1'b0);
        chk("busy_before_rst", OW'(busy), OW'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid",  OW'(out_valid),  OW'(0));
        chk("midrst_busy",       OW'(busy),       OW'(0));
        chk("midrst_psum_ready", OW'(psum_ready), OW'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready_after", OW'(psum_ready), OW'(1));
        send_beat(lane0(7), 1, 0, 1'b0);
        wait_out(d, c);
        chk("after_rst_lane0", OW'(d[7:0]), OW'(7));
        drain(50);

        // 255 full-scale beats: no accumulator wrap
        pd = '0;
        for (int i = 0; i < LANES; i++) pd[i*PSUM_W +: PSUM_W] = PSUM_W'((1 << 21) - 1);
        for (int b = 0; b < 255; b++) send_beat(pd, 255, 0, 1'b0);
        wait_out(d, c);
        chk("max255_sat", d, {LANES{8'h7F}});
        drain(50);
        for (int b = 0; b < 255; b++) send_beat(pd, 255, 23, 1'b0);
        wait_out(d, c);
        chk("max255_shift23", d, {LANES{8'h40}});
        drain(50);

        // Randomized groups with random gaps, back-pressure and cfg churn
        ready_pct = 60;
        for (int g = 0; g < 80; g++) begin
            nc = int'($urandom_range(0, 6));
            nb = (nc == 0) ? 1 : nc;
            sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
            rl = 1'(($urandom) & 1);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < LANES; i++) pd[i*PSUM_W +: PSUM_W] = PSUM_W'($urandom);
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
                if (b == 0) send_beat(pd, nc, sh, rl);
                else        send_beat(pd, int'($urandom_range(0, 255)),
                                      int'($urandom_range(0, 31)), 1'(($urandom) & 1));
            end
        end
        drain(2000);
        chk("final_queue_empty", OW'(exp_q.size()), OW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_psum_post_proc
`default_nettype wire
